// File: rtl/seq_bin_to_bcd_if.sv
// Handshake and result bus for the sequential binary-to-BCD converter.
interface seq_bin_to_bcd_if #(
    parameter int unsigned IN_W   = 10,
    parameter int unsigned DIGITS = 4
);
    logic                  start;
    logic [IN_W-1:0]       bin_in;
    logic                  ready;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  overflow;

    // Requester side: issues start/bin_in and observes status and result
    modport master (
        output start,
        output bin_in,
        input  ready,
        input  busy,
        input  done,
        input  bcd_out,
        input  overflow
    );

    // Converter side
    modport slave (
        input  start,
        input  bin_in,
        output ready,
        output busy,
        output done,
        output bcd_out,
        output overflow
    );
endinterface

// File: rtl/seq_bin_to_bcd.sv
// Sequential double-dabble binary-to-BCD converter: one shift step per clock,
// start/busy/done handshake, sticky overflow when the value exceeds DIGITS digits.
module seq_bin_to_bcd #(
    parameter int unsigned IN_W   = 10,
    parameter int unsigned DIGITS = 4
) (
    input  logic               clk,
    input  logic               rst,
    seq_bin_to_bcd_if.slave    bus
);
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(IN_W + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_nxt;

    logic [IN_W-1:0]    shift_q;
    logic [BCD_W-1:0]   scratch_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               sticky_q;

    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   scratch_nxt;
    logic               carry;
    logic               last;

    logic               accept;
    logic               step;
    logic               finish;

    logic               ready_q;
    logic               busy_q;
    logic               done_q;
    logic [BCD_W-1:0]   bcd_q;
    logic               overflow_q;

    // Add-3 correction per digit, then the one-bit shift of {scratch, shift_reg}
    always_comb begin
        adj = scratch_q;
        for (int d = 0; d < int'(DIGITS); d++) begin
            adj[4*d +: 4] = (scratch_q[4*d +: 4] >= 4'd5) ? scratch_q[4*d +: 4] + 4'd3
                                                          : scratch_q[4*d +: 4];
        end
        scratch_nxt = {adj[BCD_W-2:0], shift_q[IN_W-1]};
        carry       = adj[BCD_W-1];
        last        = (cnt_q == CNT_W'(1));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_nxt = SHIFT;
            SHIFT:   if (last)      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM control strobes
    always_comb begin
        accept = 1'b0;
        step   = 1'b0;
        finish = 1'b0;
        case (state_q)
            IDLE:    accept = bus.start;
            SHIFT: begin
                step   = 1'b1;
                finish = last;
            end
            default: ;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            sticky_q   <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            ready_q <= (state_nxt == IDLE);
            busy_q  <= (state_nxt == SHIFT);
            done_q  <= finish;
            if (accept) begin
                shift_q   <= bus.bin_in;
                scratch_q <= '0;
                sticky_q  <= 1'b0;
                cnt_q     <= CNT_W'(IN_W);
            end
            if (step) begin
                shift_q   <= shift_q << 1;
                scratch_q <= scratch_nxt;
                sticky_q  <= sticky_q | carry;
                cnt_q     <= cnt_q - CNT_W'(1);
            end
            if (finish) begin
                bcd_q      <= scratch_nxt;
                overflow_q <= sticky_q | carry;
            end
        end
    end

    assign bus.ready    = ready_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.bcd_out  = bcd_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_seq_bin_to_bcd.sv
// Directed bench for seq_bin_to_bcd across three parameterisations.
module tb_seq_bin_to_bcd;
    logic clk;
    logic rst;

    int checks;
    int errors;

    seq_bin_to_bcd_if #(.IN_W(10), .DIGITS(4)) a4 ();
    seq_bin_to_bcd_if #(.IN_W(10), .DIGITS(3)) a3 ();
    seq_bin_to_bcd_if #(.IN_W(4),  .DIGITS(1)) a1 ();

    seq_bin_to_bcd #(.IN_W(10), .DIGITS(4)) u4 (.clk(clk), .rst(rst), .bus(a4));
    seq_bin_to_bcd #(.IN_W(10), .DIGITS(3)) u3 (.clk(clk), .rst(rst), .bus(a3));
    seq_bin_to_bcd #(.IN_W(4),  .DIGITS(1)) u1 (.clk(clk), .rst(rst), .bus(a1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start a conversion on the 4-digit unit and wait (bounded) for done.
    // m = cycles after the accepting edge until done is seen; bc = busy cycles seen.
    task automatic run4(input logic [9:0] v, output int m, output int bc);
        a4.start  = 1'b1;
        a4.bin_in = v;
        @(posedge clk);
        @(negedge clk);
        a4.start = 1'b0;
        m  = 0;
        bc = 0;
        while (!a4.done && m < 40) begin
            if (a4.busy) bc++;
            @(negedge clk);
            m++;
        end
    endtask

    task automatic run3(input logic [9:0] v, output int m);
        a3.start  = 1'b1;
        a3.bin_in = v;
        @(posedge clk);
        @(negedge clk);
        a3.start = 1'b0;
        m = 0;
        while (!a3.done && m < 40) begin
            @(negedge clk);
            m++;
        end
    endtask

    task automatic run1(input logic [3:0] v, output int m);
        a1.start  = 1'b1;
        a1.bin_in = v;
        @(posedge clk);
        @(negedge clk);
        a1.start = 1'b0;
        m = 0;
        while (!a1.done && m < 40) begin
            @(negedge clk);
            m++;
        end
    endtask

    initial begin
        int m;
        int bc;
        int dc;
        int first;
        logic [15:0] res;

        checks = 0;
        errors = 0;
        rst = 1'b1;
        a4.start = 1'b0; a4.bin_in = '0;
        a3.start = 1'b0; a3.bin_in = '0;
        a1.start = 1'b0; a1.bin_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_ready", 32'(a4.ready), 32'd1);
        chk("rst_busy", 32'(a4.busy), 32'd0);
        chk("rst_done", 32'(a4.done), 32'd0);
        chk("rst_bcd", 32'(a4.bcd_out), 32'h0);
        chk("rst_ovf", 32'(a4.overflow), 32'd0);

        // 999 on 4 digits: done 10 cycles after acceptance, busy exactly 10 cycles
        run4(10'd999, m, bc);
        chk("t1_latency", 32'(m), 32'd10);
        chk("t1_busy_cycles", 32'(bc), 32'd10);
        chk("t1_bcd", 32'(a4.bcd_out), 32'h0999);
        chk("t1_ovf", 32'(a4.overflow), 32'd0);
        chk("t1_busy_at_done", 32'(a4.busy), 32'd0);
        chk("t1_ready_at_done", 32'(a4.ready), 32'd1);
        @(negedge clk);
        chk("t1_done_one_cycle", 32'(a4.done), 32'd0);

        // 1023, then 0 started in the done cycle
        run4(10'd1023, m, bc);
        chk("t2a_latency", 32'(m), 32'd10);
        chk("t2a_bcd", 32'(a4.bcd_out), 32'h1023);
        chk("t2a_ovf", 32'(a4.overflow), 32'd0);
        a4.start  = 1'b1;
        a4.bin_in = 10'd0;
        @(posedge clk);
        @(negedge clk);
        a4.start = 1'b0;
        chk("t2b_accepted_busy", 32'(a4.busy), 32'd1);
        chk("t2b_bcd_holds", 32'(a4.bcd_out), 32'h1023);
        m = 0;
        while (!a4.done && m < 40) begin
            @(negedge clk);
            m++;
        end
        chk("t2b_latency", 32'(m), 32'd10);
        chk("t2b_bcd", 32'(a4.bcd_out), 32'h0000);
        chk("t2b_ovf", 32'(a4.overflow), 32'd0);

        // 3 digits: overflow then exact
        run3(10'd1023, m);
        chk("t3a_latency", 32'(m), 32'd10);
        chk("t3a_bcd", 32'(a3.bcd_out), 32'h023);
        chk("t3a_ovf", 32'(a3.overflow), 32'd1);
        run3(10'd999, m);
        chk("t3b_bcd", 32'(a3.bcd_out), 32'h999);
        chk("t3b_ovf", 32'(a3.overflow), 32'd0);

        // 4-bit input, 1 digit
        run1(4'd12, m);
        chk("t4a_latency", 32'(m), 32'd4);
        chk("t4a_bcd", 32'(a1.bcd_out), 32'h2);
        chk("t4a_ovf", 32'(a1.overflow), 32'd1);
        run1(4'd9, m);
        chk("t4b_bcd", 32'(a1.bcd_out), 32'h9);
        chk("t4b_ovf", 32'(a1.overflow), 32'd0);

        // start during busy is ignored
        a4.start  = 1'b1;
        a4.bin_in = 10'd500;
        @(posedge clk);
        @(negedge clk);
        a4.start = 1'b0;
        dc    = 0;
        first = -1;
        res   = 16'h0;
        for (int i = 0; i < 25; i++) begin
            if (i == 2) begin
                a4.start  = 1'b1;
                a4.bin_in = 10'd7;
            end else begin
                a4.start = 1'b0;
            end
            if (a4.done) begin
                dc++;
                if (first < 0) begin
                    first = i;
                    res   = a4.bcd_out;
                end
            end
            @(negedge clk);
        end
        a4.start = 1'b0;
        chk("t5_done_count", 32'(dc), 32'd1);
        chk("t5_latency", 32'(first), 32'd10);
        chk("t5_bcd", 32'(res), 32'h0500);

        // reset mid-conversion aborts
        a4.start  = 1'b1;
        a4.bin_in = 10'd777;
        @(posedge clk);
        @(negedge clk);
        a4.start = 1'b0;
        dc = 0;
        for (int i = 0; i < 4; i++) begin
            if (a4.done) dc++;
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (a4.done) dc++;
            if (i == 0) begin
                chk("t6_bcd_cleared", 32'(a4.bcd_out), 32'h0);
                chk("t6_ovf_cleared", 32'(a4.overflow), 32'd0);
                chk("t6_ready", 32'(a4.ready), 32'd1);
                chk("t6_busy", 32'(a4.busy), 32'd0);
            end
            @(negedge clk);
        end
        chk("t6_no_done", 32'(dc), 32'd0);
        run4(10'd42, m, bc);
        chk("t6_latency", 32'(m), 32'd10);
        chk("t6_bcd", 32'(a4.bcd_out), 32'h0042);
        chk("t6_ovf", 32'(a4.overflow), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
